// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the ALU drive/return bus and the response
// channel shared between alu_arbiter (slave) and its environment (master).
interface alu_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
);
    logic                   req0_valid;
    logic [DATA_WIDTH-1:0]  req0_op1;
    logic [DATA_WIDTH-1:0]  req0_op2;
    logic [FUNCT_WIDTH-1:0] req0_funct;
    logic                   req0_ready;

    logic                   req1_valid;
    logic [DATA_WIDTH-1:0]  req1_op1;
    logic [DATA_WIDTH-1:0]  req1_op2;
    logic [FUNCT_WIDTH-1:0] req1_funct;
    logic                   req1_ready;

    logic [DATA_WIDTH-1:0]  alu_op1;
    logic [DATA_WIDTH-1:0]  alu_op2;
    logic [FUNCT_WIDTH-1:0] alu_funct;
    logic [DATA_WIDTH-1:0]  alu_result;

    logic                   rsp_valid;
    logic                   rsp_id;
    logic [DATA_WIDTH-1:0]  rsp_result;
    logic                   rsp_err;
    logic                   rsp_ready;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_funct,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_funct,
        output req1_ready,
        output alu_op1, alu_op2, alu_funct,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_funct,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_funct,
        input  req1_ready,
        input  alu_op1, alu_op2, alu_funct,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters: grant in IDLE, drive the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   id_q;
    logic   illegal_q;
    logic   grant0;
    logic   grant1;

    function automatic logic is_legal(input logic [FUNCT_WIDTH-1:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            FUNCT_WIDTH'(6'h20), FUNCT_WIDTH'(6'h22), FUNCT_WIDTH'(6'h2c),
            FUNCT_WIDTH'(6'h01), FUNCT_WIDTH'(6'h02), FUNCT_WIDTH'(6'h24),
            FUNCT_WIDTH'(6'h25), FUNCT_WIDTH'(6'h27), FUNCT_WIDTH'(6'h2a): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Grant only from IDLE; with both valid the prio pointer picks the winner.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !prio)) begin
                    grant0    = 1'b1;
                    state_nxt = EXEC;
                end else if (bus.req1_valid) begin
                    grant1    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = grant0 & ~rst;
    assign bus.req1_ready = grant1 & ~rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio           <= 1'b0;
            id_q           <= 1'b0;
            illegal_q      <= 1'b0;
            bus.alu_op1    <= {DATA_WIDTH{1'b0}};
            bus.alu_op2    <= {DATA_WIDTH{1'b0}};
            bus.alu_funct  <= {FUNCT_WIDTH{1'b0}};
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= {DATA_WIDTH{1'b0}};
            bus.rsp_err    <= 1'b0;
        end else begin
            // Grant cycle: the only place request inputs are sampled.
            if (grant0) begin
                bus.alu_op1   <= bus.req0_op1;
                bus.alu_op2   <= bus.req0_op2;
                bus.alu_funct <= bus.req0_funct;
                id_q          <= 1'b0;
                illegal_q     <= ~is_legal(bus.req0_funct);
            end else if (grant1) begin
                bus.alu_op1   <= bus.req1_op1;
                bus.alu_op2   <= bus.req1_op2;
                bus.alu_funct <= bus.req1_funct;
                id_q          <= 1'b1;
                illegal_q     <= ~is_legal(bus.req1_funct);
            end

            // EXEC: ALU inputs have been stable all cycle, capture its result.
            if (state == EXEC) begin
                bus.rsp_result <= illegal_q ? {DATA_WIDTH{1'b0}} : bus.alu_result;
                bus.rsp_err    <= illegal_q;
                bus.rsp_id     <= id_q;
                bus.rsp_valid  <= 1'b1;
            end

            // RESP: the served requester hands priority to the other one.
            if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                prio          <= ~bus.rsp_id;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model with a
// per-cycle compare process, directed literal scenarios and a random phase.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    alu_arbiter_if #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit [5:0] legal_tab [9] = '{6'h20, 6'h22, 6'h2c, 6'h01, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2a};

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] f);
        logic [31:0] r;
        case (f)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h2c:   r = a * b;
            6'h01:   r = a << b[4:0];
            6'h02:   r = a >> b[4:0];
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h27:   r = ~(a | b);
            6'h2a:   r = {31'd0, (a < b)};
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    function automatic bit legal(input logic [5:0] f);
        bit ok = 1'b0;
        for (int i = 0; i < 9; i++) if (legal_tab[i] == f) ok = 1'b1;
        return ok;
    endfunction

    assign bus.alu_result = alu_model(bus.alu_op1, bus.alu_op2, bus.alu_funct);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: at most one operation outstanding; m_age counts cycles since accept.
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_prio = 0;
    bit          m_id   = 0;
    logic [31:0] m_res  = 0;
    bit          m_err  = 0;
    logic [31:0] m_op1  = 0;
    logic [31:0] m_op2  = 0;
    logic [5:0]  m_funct = 0;
    int          log_id [$];
    logic [31:0] log_res [$];
    int          log_cyc [$];

    always @(negedge clk) begin : monitor
        bit e0, e1, ev;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst && !m_busy) begin
            e0 = bus.req0_valid && (!bus.req1_valid || m_prio == 1'b0);
            e1 = bus.req1_valid && !e0;
        end
        ev = m_busy && m_age >= 2;
        check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
        check("alu_op1", bus.alu_op1, m_op1);
        check("alu_op2", bus.alu_op2, m_op2);
        check("alu_funct", {26'd0, bus.alu_funct}, {26'd0, m_funct});
        check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
        if (ev) begin
            check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, m_id});
            check("rsp_result", bus.rsp_result, m_res);
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_err});
        end
        if (rst) begin
            m_busy = 0; m_age = 0; m_prio = 0; m_id = 0;
            m_op1 = 0; m_op2 = 0; m_funct = 0;
        end else if (!m_busy) begin
            if (e0 || e1) begin
                m_busy  = 1; m_age = 1; m_id = e1;
                m_op1   = e1 ? bus.req1_op1 : bus.req0_op1;
                m_op2   = e1 ? bus.req1_op2 : bus.req0_op2;
                m_funct = e1 ? bus.req1_funct : bus.req0_funct;
                m_err   = !legal(m_funct);
                m_res   = m_err ? 32'd0 : alu_model(m_op1, m_op2, m_funct);
            end
        end else if (m_age >= 2) begin
            if (bus.rsp_ready) begin
                log_id.push_back(int'(bus.rsp_id));
                log_res.push_back(bus.rsp_result);
                log_cyc.push_back(cyc);
                m_busy = 0;
                m_prio = ~m_id;
            end
        end else begin
            m_age = 2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f);
        bit got = 1'b0;
        if (id) begin
            bus.req1_valid = 1; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_funct = f;
        end else begin
            bus.req0_valid = 1; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_funct = f;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL issue_timeout: requester %0d never granted, required grant within 20 cycles", id);
        end
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid === 1'b1) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL rsp_timeout: rsp_valid low for 10 cycles, required high");
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1;
        bus.req0_valid = 0; bus.req0_op1 = 0; bus.req0_op2 = 0; bus.req0_funct = 0;
        bus.req1_valid = 0; bus.req1_op1 = 0; bus.req1_op2 = 0; bus.req1_funct = 0;
        bus.rsp_ready = 1;
        tick(); tick();

        // Reset state with both requesters valid.
        bus.req0_valid = 1; bus.req1_valid = 1;
        @(negedge clk);
        check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_alu_op1", bus.alu_op1, 32'd0);
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        rst = 0;
        tick();

        // Single op: 5 - 3.
        issue(0, 32'd5, 32'd3, 6'h22);
        wait_rsp(n);
        check("single_latency", n, 32'd2);
        check("single_result", bus.rsp_result, 32'd2);
        check("single_id", {31'd0, bus.rsp_id}, 32'd0);
        check("single_err", {31'd0, bus.rsp_err}, 32'd0);
        tick(); tick();

        // Contention from a fresh reset: alternate 0,1,0,1 one per 3 cycles.
        rst = 1; tick(); rst = 0;
        log_id.delete(); log_res.delete(); log_cyc.delete();
        bus.req0_op1 = 1; bus.req0_op2 = 1; bus.req0_funct = 6'h20;
        bus.req1_op1 = 32'hF0; bus.req1_op2 = 32'h0F; bus.req1_funct = 6'h25;
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (log_id.size() >= 4) break;
        end
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        if (log_id.size() < 4) begin
            n_cmp++; n_fail++;
            $display("FAIL contention_count: got %0d responses, required 4", log_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                check("contention_id", log_id[k], k % 2);
                check("contention_result", log_res[k], (k % 2) ? 32'hFF : 32'd2);
            end
            for (int k = 0; k < 3; k++) check("contention_spacing", log_cyc[k+1] - log_cyc[k], 32'd3);
        end
        repeat (5) tick();

        // Backpressure: hold for 5 cycles with req1 waiting.
        bus.rsp_ready = 0;
        issue(0, 32'd7, 32'd8, 6'h20);
        wait_rsp(n);
        bus.req1_valid = 1; bus.req1_op1 = 32'h1234; bus.req1_funct = 6'h24;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result", bus.rsp_result, 32'd15);
            check("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            check("bp_alu_op1", bus.alu_op1, 32'd7);
        end
        tick();
        bus.req1_valid = 0;
        bus.rsp_ready = 1;
        tick();
        @(negedge clk);
        check("bp_release", {31'd0, bus.rsp_valid}, 32'd0);
        tick(); tick();

        // Illegal funct from req1; prio then favours requester 0.
        issue(1, 32'h55, 32'hAA, 6'h3F);
        wait_rsp(n);
        check("illegal_err", {31'd0, bus.rsp_err}, 32'd1);
        check("illegal_result", bus.rsp_result, 32'd0);
        check("illegal_id", {31'd0, bus.rsp_id}, 32'd1);
        tick();
        bus.req0_valid = 1; bus.req0_funct = 6'h20;
        bus.req1_valid = 1; bus.req1_funct = 6'h20;
        @(negedge clk);
        check("illegal_prio0", {31'd0, bus.req0_ready}, 32'd1);
        check("illegal_prio1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (4) tick();

        // Reset during EXEC discards the operation.
        issue(0, 32'd9, 32'd4, 6'h20);
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("rstexec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstexec_alu_op1", bus.alu_op1, 32'd0);
        check("rstexec_alu_funct", {26'd0, bus.alu_funct}, 32'd0);
        tick();
        issue(1, 32'h30, 32'd3, 6'h02);
        wait_rsp(n);
        check("rstexec_next_result", bus.rsp_result, 32'd6);
        check("rstexec_next_id", {31'd0, bus.rsp_id}, 32'd1);
        tick(); tick();

        // Width / wrap behaviour.
        issue(0, 32'h10000, 32'h10000, 6'h2c);
        wait_rsp(n);
        check("mul_wrap", bus.rsp_result, 32'd0);
        tick(); tick();
        issue(0, 32'd1, 32'd31, 6'h01);
        wait_rsp(n);
        check("sll_31", bus.rsp_result, 32'h8000_0000);
        tick(); tick();
        issue(1, 32'hFFFF_FFFF, 32'd1, 6'h2a);
        wait_rsp(n);
        check("slt_unsigned", bus.rsp_result, 32'd0);
        tick(); tick();

        // Random phase against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_op1 = $urandom; bus.req0_op2 = $urandom;
            bus.req1_op1 = $urandom; bus.req1_op2 = $urandom;
            bus.req0_funct = ($urandom_range(0, 4) != 0) ? legal_tab[$urandom_range(0, 8)] : 6'($urandom);
            bus.req1_funct = ($urandom_range(0, 4) != 0) ? legal_tab[$urandom_range(0, 8)] : 6'($urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp_ready = 1;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
